// File: rtl/mult_pow_pipe_if.sv
// Valid/ready streaming bundle for the scaled-power multiplier: operand pair in, result out.
interface mult_pow_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, ovf
  );
endinterface

// File: rtl/mult_pow_pipe.sv
// Fully pipelined out = a * b^STAGES, one multiply by b per stage, with
// valid/ready backpressure, sticky per-item overflow and optional saturation.
module mult_pow_pipe #(
  parameter int WIDTH    = 16,
  parameter int STAGES   = 3,
  parameter int SATURATE = 0
) (
  input logic           clk,
  input logic           rst,
  mult_pow_pipe_if.slave s
);

  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] v,
                                                input logic             ovf_in);
    return ((SATURATE != 0) && ovf_in) ? '1 : v;
  endfunction

  // Returns {sticky overflow, partial product} for one stage.
  function automatic logic [WIDTH:0] mul_stage(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             ovf_in);
    logic [2*WIDTH-1:0] prod;
    logic               ovf_o;
    prod  = (2*WIDTH)'(x) * (2*WIDTH)'(y);
    ovf_o = ovf_in | (|prod[2*WIDTH-1:WIDTH]);
    return {ovf_o, saturate(prod[WIDTH-1:0], ovf_o)};
  endfunction

  logic             advance;
  logic             in_xfer;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0]  p_q [STAGES];
  logic [WIDTH-1:0]  p_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];

  assign advance    = !vld_q[STAGES-1] || s.out_ready;
  assign s.in_ready = advance && !rst;
  assign in_xfer    = s.in_valid && s.in_ready;

  // Bubbles enter as zero data so the output reads 0 until a real result arrives.
  always_comb begin
    vld_d = vld_q;
    ovf_d = ovf_q;
    p_d   = p_q;
    b_d   = b_q;
    if (advance) begin
      vld_d[0]            = in_xfer;
      {ovf_d[0], p_d[0]}  = in_xfer ? mul_stage(s.a, s.b, 1'b0) : '0;
      b_d[0]              = in_xfer ? s.b : '0;
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k]           = vld_q[k-1];
        {ovf_d[k], p_d[k]} = mul_stage(p_q[k-1], b_q[k-1], ovf_q[k-1]);
        b_d[k]             = b_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ovf_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        p_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        p_q[k] <= p_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

  assign s.out_valid = vld_q[STAGES-1];
  assign s.out       = p_q[STAGES-1];
  assign s.ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_mult_pow_pipe.sv
// Lockstep bench for four configurations of mult_pow_pipe against a
// plain-arithmetic reference of a*b^STAGES with per-item overflow.
module tb_mult_pow_pipe;

  localparam int CW  [4] = '{8, 8, 16, 16};
  localparam int CS  [4] = '{3, 3, 1, 3};
  localparam int CSAT[4] = '{0, 1, 0, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;

  always #5 clk = ~clk;

  mult_pow_pipe_if #(.WIDTH(8))  if0 ();
  mult_pow_pipe_if #(.WIDTH(8))  if1 ();
  mult_pow_pipe_if #(.WIDTH(16)) if2 ();
  mult_pow_pipe_if #(.WIDTH(16)) if3 ();

  mult_pow_pipe #(.WIDTH(8),  .STAGES(3), .SATURATE(0)) u0 (.clk(clk), .rst(rst), .s(if0));
  mult_pow_pipe #(.WIDTH(8),  .STAGES(3), .SATURATE(1)) u1 (.clk(clk), .rst(rst), .s(if1));
  mult_pow_pipe #(.WIDTH(16), .STAGES(1), .SATURATE(0)) u2 (.clk(clk), .rst(rst), .s(if2));
  mult_pow_pipe #(.WIDTH(16), .STAGES(3), .SATURATE(1)) u3 (.clk(clk), .rst(rst), .s(if3));

  assign if0.in_valid = in_valid;  assign if0.a = a_in[7:0]; assign if0.b = b_in[7:0];
  assign if1.in_valid = in_valid;  assign if1.a = a_in[7:0]; assign if1.b = b_in[7:0];
  assign if2.in_valid = in_valid;  assign if2.a = a_in;      assign if2.b = b_in;
  assign if3.in_valid = in_valid;  assign if3.a = a_in;      assign if3.b = b_in;
  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;
  assign if2.out_ready = out_ready;
  assign if3.out_ready = out_ready;

  logic        rdy  [4];
  logic        vld  [4];
  logic        ovf  [4];
  logic [15:0] dout [4];

  assign rdy[0] = if0.in_ready;  assign vld[0] = if0.out_valid;
  assign rdy[1] = if1.in_ready;  assign vld[1] = if1.out_valid;
  assign rdy[2] = if2.in_ready;  assign vld[2] = if2.out_valid;
  assign rdy[3] = if3.in_ready;  assign vld[3] = if3.out_valid;
  assign ovf[0] = if0.ovf;       assign dout[0] = {8'h00, if0.out};
  assign ovf[1] = if1.ovf;       assign dout[1] = {8'h00, if1.out};
  assign ovf[2] = if2.ovf;       assign dout[2] = if2.out;
  assign ovf[3] = if3.ovf;       assign dout[3] = if3.out;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: exact partial products until one leaves WIDTH bits, wrapped value in parallel.
  function automatic logic [16:0] model(input int unsigned a, input int unsigned b,
                                        input int w, input int st, input int sat);
    longint unsigned lim, ex, wr, bm;
    bit              o;
    logic [15:0]     r;
    lim = 64'd1 << w;
    ex  = longint'(a) % lim;
    bm  = longint'(b) % lim;
    wr  = ex;
    o   = 1'b0;
    for (int k = 0; k < st; k++) begin
      if (!o) begin
        ex = ex * bm;
        if (ex >= lim) o = 1'b1;
      end
      wr = (wr * bm) % lim;
    end
    r = (sat != 0 && o) ? 16'(lim - 1) : 16'(wr);
    return {o, r};
  endfunction

  logic [16:0] q    [4][$];
  bit          seen [4];
  bit          hold [4];
  logic [16:0] prev [4];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      check($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'((!vld[i] || out_ready) && !rst));
      if (rst) begin
        q[i].delete();
        seen[i] = 1'b0;
        hold[i] = 1'b0;
      end else begin
        if (hold[i]) begin
          check($sformatf("stall_valid[%0d]", i), 32'(vld[i]), 32'd1);
          check($sformatf("stall_data[%0d]", i), 32'({ovf[i], dout[i]}), 32'(prev[i]));
        end
        if (vld[i]) begin
          seen[i] = 1'b1;
          if (q[i].size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL spurious[%0d]: out_valid with no item in flight, out=0x%0h", i, dout[i]);
          end else begin
            check($sformatf("out[%0d]", i), 32'({ovf[i], dout[i]}), 32'(q[i][0]));
            if (out_ready) void'(q[i].pop_front());
          end
        end else if (!seen[i]) begin
          check($sformatf("idle_out[%0d]", i), 32'({ovf[i], dout[i]}), 32'd0);
        end
        hold[i] = vld[i] && !out_ready;
        prev[i] = {ovf[i], dout[i]};
        if (in_valid && rdy[i])
          q[i].push_back(model(a_in, b_in, CW[i], CS[i], CSAT[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(input int i, input string nm, input logic [16:0] exp);
    bit ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (vld[i]) ok = 1'b1;
    end
    if (ok) check(nm, 32'({ovf[i], dout[i]}), 32'(exp));
    else begin
      compared++;
      mismatched++;
      $display("FAIL %s: timeout waiting for out_valid, required 0x%0h", nm, exp);
    end
  endtask

  initial begin
    int cur_run;
    int max_run;
    logic [15:0] exp3 [2];
    exp3[0] = 16'd27;
    exp3[1] = 16'd64;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    step();
    step();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_vld[%0d]", i), 32'(vld[i]), 32'd0);
      check($sformatf("rst_out[%0d]", i), 32'({ovf[i], dout[i]}), 32'd0);
      check($sformatf("rst_rdy[%0d]", i), 32'(rdy[i]), 32'd0);
    end
    step();
    rst = 1'b0;
    step();

    // Single item latency: a=2, b=3
    in_valid = 1'b1; a_in = 16'd2; b_in = 16'd3;
    step();
    in_valid = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      check("lat_s3", 32'(vld[0]), 32'(e == 2));
      check("lat_s1", 32'(vld[2]), 32'(e == 0));
      if (e == 2) check("t1_out", 32'({ovf[0], dout[0]}), 32'd54);
      if (e == 0) check("t1_s1_out", 32'({ovf[2], dout[2]}), 32'd6);
    end

    // Overflow wrap vs saturate: a=2, b=16
    step();
    in_valid = 1'b1; a_in = 16'd2; b_in = 16'd16;
    step();
    in_valid = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      if (e == 0) check("t2_s1", 32'({ovf[2], dout[2]}), 32'd32);
      if (e == 2) begin
        check("t2_wrap", 32'({ovf[0], dout[0]}), 32'h10000);
        check("t2_sat", 32'({ovf[1], dout[1]}), 32'h100FF);
        check("t2_w16", 32'({ovf[3], dout[3]}), 32'd8192);
      end
    end

    // Backpressure: three items, consumer stalls 4 cycles on first result
    step();
    in_valid = 1'b1; a_in = 16'd1; b_in = 16'd2;
    step();
    b_in = 16'd3;
    step();
    b_in = 16'd4;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t3_hold", 32'({vld[0], ovf[0], dout[0]}), 32'h20008);
      check("t3_rdy", 32'(rdy[0]), 32'd0);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_first", 32'({vld[0], ovf[0], dout[0]}), 32'h20008);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check("t3_next", 32'({vld[0], ovf[0], dout[0]}), 32'h20000 | 32'(exp3[j]));
    end
    @(negedge clk);
    check("t3_done", 32'(vld[0]), 32'd0);

    // Full-rate burst of 10 random items
    cur_run = 0; max_run = 0;
    for (int c = 0; c < 18; c++) begin
      step();
      in_valid = (c < 10);
      a_in = 16'($urandom);
      b_in = 16'($urandom_range(0, 6));
      @(negedge clk);
      if (vld[0]) begin
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else cur_run = 0;
    end
    check("t4_run", 32'(max_run), 32'd10);

    // Reset with two items in flight
    step();
    in_valid = 1'b1; a_in = 16'd7; b_in = 16'd9;
    step();
    a_in = 16'd5;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rdy_rst", 32'(rdy[0]), 32'd0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5_flushed", 32'({vld[0], ovf[0], dout[0]}), 32'd0);
    end
    step();
    in_valid = 1'b1; a_in = 16'd3; b_in = 16'd5;
    step();
    in_valid = 1'b0;
    wait_vld(0, "t5_after", 17'h10077);

    // Wide operands: single-stage wrap and three-stage saturation
    step();
    in_valid = 1'b1; a_in = 16'd300; b_in = 16'd300;
    step();
    in_valid = 1'b0;
    wait_vld(2, "t6_s1", 17'h15F90);
    wait_vld(3, "t6_sat", 17'h1FFFF);

    // Randomized traffic with random stalls and occasional reset
    for (int c = 0; c < 3000; c++) begin
      step();
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a_in      = 16'($urandom);
      b_in      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 5));
    end
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) step();
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("drain[%0d]", i), 32'(q[i].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
